// File: rtl/dm_bus_ctrl_pkg.sv
// Shared constants for dm_bus_ctrl: slave address map, slave select indices
// and the 2-bit FSM state encodings.
package dm_bus_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam int SLV_DM  = 0;
    localparam int SLV_TC0 = 1;
    localparam int SLV_TC1 = 2;
    localparam int SLV_IG  = 3;

    // Inclusive byte-address bounds of each slave window.
    localparam logic [31:0] DM_LO  = 32'h0000_0000;
    localparam logic [31:0] DM_HI  = 32'h0000_2FFF;
    localparam logic [31:0] TC0_LO = 32'h0000_7F00;
    localparam logic [31:0] TC0_HI = 32'h0000_7F0B;
    localparam logic [31:0] TC1_LO = 32'h0000_7F10;
    localparam logic [31:0] TC1_HI = 32'h0000_7F1B;
    localparam logic [31:0] IG_LO  = 32'h0000_7F20;
    localparam logic [31:0] IG_HI  = 32'h0000_7F23;

    function automatic logic in_range(input logic [31:0] a,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder: one-hot slave select plus a hole flag for
// addresses outside every slave window.
module bus_addr_decode
    import dm_bus_ctrl_pkg::*;
(
    input  logic [31:0] i_addr,
    output logic [3:0]  o_sel,
    output logic        o_hole
);

    // NOTE: every bit gets a value on every path, so no latch is inferred.
    always_comb begin
        o_sel          = 4'b0000;
        o_sel[SLV_DM]  = in_range(i_addr, DM_LO,  DM_HI);
        o_sel[SLV_TC0] = in_range(i_addr, TC0_LO, TC0_HI);
        o_sel[SLV_TC1] = in_range(i_addr, TC1_LO, TC1_HI);
        o_sel[SLV_IG]  = in_range(i_addr, IG_LO,  IG_HI);
    end

    assign o_hole = ~|o_sel;

endmodule

// File: rtl/dm_bus_ctrl.sv
// CPU data-bus controller: decodes an access onto four slaves, waits for the
// selected ack with a timeout, and returns a one-cycle ready/err response.
// Optional statistics counters are built when BUS_STATS_EN is defined.
module dm_bus_ctrl
    import dm_bus_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byteen,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic [3:0]  s_sel,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_byteen,
    input  logic [3:0]  s_ack,
    input  logic [31:0] s_rdata_dm,
    input  logic [31:0] s_rdata_tc0,
    input  logic [31:0] s_rdata_tc1,
    input  logic [31:0] s_rdata_ig,
    output logic [15:0] stat_txn_cnt,
    output logic [15:0] stat_err_cnt
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]       r_state;
    logic [3:0]       r_sel;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_byteen;
    logic [31:0]      r_rdata;
    logic [CNT_W-1:0] r_cnt;

    logic [3:0]  w_dec_sel;
    logic        w_dec_hole;
    logic        w_ack;
    logic        w_timeout;
    logic [31:0] w_slave_rdata;

    bus_addr_decode u_decode (
        .i_addr (cpu_addr),
        .o_sel  (w_dec_sel),
        .o_hole (w_dec_hole)
    );

    // Only the ack bit of the currently selected slave counts.
    assign w_ack     = |(s_ack & r_sel);
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_slave_rdata = 32'h0;
        if (r_sel[SLV_DM])  w_slave_rdata = s_rdata_dm;
        if (r_sel[SLV_TC0]) w_slave_rdata = s_rdata_tc0;
        if (r_sel[SLV_TC1]) w_slave_rdata = s_rdata_tc1;
        if (r_sel[SLV_IG])  w_slave_rdata = s_rdata_ig;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_sel    <= 4'b0000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_byteen <= 4'b0000;
            r_rdata  <= 32'h0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        if (w_dec_hole) begin
                            r_state <= ST_ERR;
                        end else begin
                            r_addr   <= cpu_addr;
                            r_wdata  <= cpu_wdata;
                            r_byteen <= cpu_byteen;
                            r_sel    <= w_dec_sel;
                            r_cnt    <= '0;
                            r_state  <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // An ack in the final timeout cycle still completes normally.
                    if (w_ack) begin
                        r_rdata <= w_slave_rdata;
                        r_sel   <= 4'b0000;
                        r_state <= ST_RESP;
                    end else begin
                        if (r_cnt != CNT_W'(TIMEOUT_CYCLES)) r_cnt <= r_cnt + 1'b1;
                        if (w_timeout) begin
                            r_sel   <= 4'b0000;
                            r_state <= ST_ERR;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cpu_ready = (r_state == ST_RESP) || (r_state == ST_ERR);
    assign cpu_err   = (r_state == ST_ERR);
    assign cpu_rdata = ((r_state == ST_RESP) && (r_byteen == 4'b0000)) ? r_rdata : 32'h0;
    assign s_sel     = r_sel;
    assign s_addr    = r_addr;
    assign s_wdata   = r_wdata;
    assign s_byteen  = r_byteen;

`ifdef BUS_STATS_EN
    logic [15:0] r_txn_cnt;
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_txn_cnt <= 16'h0;
            r_err_cnt <= 16'h0;
        end else begin
            if (cpu_ready && (r_txn_cnt != 16'hFFFF)) r_txn_cnt <= r_txn_cnt + 16'h1;
            if (cpu_err && (r_err_cnt != 16'hFFFF))   r_err_cnt <= r_err_cnt + 16'h1;
        end
    end

    assign stat_txn_cnt = r_txn_cnt;
    assign stat_err_cnt = r_err_cnt;
`else
    assign stat_txn_cnt = 16'h0;
    assign stat_err_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_dm_bus_ctrl.sv
// Self-checking bench for dm_bus_ctrl: directed and random accesses scored
// against an address-map / latency model.
module tb_dm_bus_ctrl;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byteen;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic [3:0]  s_sel;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_byteen;
    logic [3:0]  s_ack;
    logic [31:0] slave_data [4];
    logic [15:0] stat_txn_cnt;
    logic [15:0] stat_err_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int exp_txn = 0;
    int exp_err = 0;

    always #5 clk = ~clk;

    dm_bus_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_byteen   (cpu_byteen),
        .cpu_ready    (cpu_ready),
        .cpu_rdata    (cpu_rdata),
        .cpu_err      (cpu_err),
        .s_sel        (s_sel),
        .s_addr       (s_addr),
        .s_wdata      (s_wdata),
        .s_byteen     (s_byteen),
        .s_ack        (s_ack),
        .s_rdata_dm   (slave_data[0]),
        .s_rdata_tc0  (slave_data[1]),
        .s_rdata_tc1  (slave_data[2]),
        .s_rdata_ig   (slave_data[3]),
        .stat_txn_cnt (stat_txn_cnt),
        .stat_err_cnt (stat_err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Address map as a plain window table.
    function automatic logic [3:0] ref_sel(input logic [31:0] a);
        if (a <= 32'h2FFF)                   return 4'b0001;
        if (a >= 32'h7F00 && a <= 32'h7F0B)  return 4'b0010;
        if (a >= 32'h7F10 && a <= 32'h7F1B)  return 4'b0100;
        if (a >= 32'h7F20 && a <= 32'h7F23)  return 4'b1000;
        return 4'b0000;
    endfunction

    function automatic int sel_index(input logic [3:0] sel);
        for (int i = 0; i < 4; i++) if (sel[i]) return i;
        return 0;
    endfunction

    // ack_delay = index of the WAIT cycle carrying the real ack (>= TO: never).
    task automatic run_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int ack_delay, input bit drop_req);
        logic [3:0]  esel;
        bit          hole;
        bit          exp_e;
        int          exp_lat;
        logic [31:0] exp_rd;
        int          lat;
        int          sel_cycles;
        bit          sel_bad;
        bit          got;
        logic [31:0] rd;
        logic        err;
        esel       = ref_sel(addr);
        hole       = (esel == 4'b0000);
        exp_e      = hole || (ack_delay >= TO);
        exp_lat    = hole ? 1 : ((ack_delay >= TO) ? TO + 1 : ack_delay + 2);
        for (int i = 0; i < 4; i++) slave_data[i] = $urandom;
        exp_rd     = (exp_e || be != 4'b0000) ? 32'h0 : slave_data[sel_index(esel)];
        sel_cycles = 0;
        sel_bad    = 1'b0;
        got        = 1'b0;
        rd         = 32'h0;
        err        = 1'b0;

        @(negedge clk);
        cpu_req    = 1'b1;
        cpu_addr   = addr;
        cpu_wdata  = wdata;
        cpu_byteen = be;
        s_ack      = 4'($urandom);
        @(posedge clk); #1;
        lat = 1;
        while (!got && lat <= 40) begin
            if (s_sel !== 4'b0000) begin
                sel_cycles++;
                if (s_sel !== esel) sel_bad = 1'b1;
            end
            if (cpu_ready === 1'b1) begin
                got = 1'b1;
                rd  = cpu_rdata;
                err = cpu_err;
            end else begin
                if (lat == 1 && !hole) begin
                    check({tag, "_s_addr"},   s_addr,   addr);
                    check({tag, "_s_wdata"},  s_wdata,  wdata);
                    check({tag, "_s_byteen"}, 32'(s_byteen), 32'(be));
                end
                if (drop_req) cpu_req = 1'b0;
                if (lat - 1 == ack_delay) s_ack = esel | (4'($urandom) & ~esel);
                else                      s_ack = 4'($urandom) & ~esel;
                @(posedge clk); #1;
                lat++;
            end
        end
        check({tag, "_ready_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"},    32'(lat), 32'(exp_lat));
        check({tag, "_err"},        32'(err), 32'(exp_e));
        check({tag, "_rdata"},      rd,       exp_rd);
        check({tag, "_sel_cycles"}, 32'(sel_cycles), 32'(exp_lat - 1));
        check({tag, "_sel_onehot"}, 32'(sel_bad), 32'd0);
`ifdef BUS_STATS_EN
        if (exp_txn < 65535) exp_txn++;
        if (exp_e && exp_err < 65535) exp_err++;
`endif
        cpu_req = 1'b0;
        s_ack   = 4'($urandom);
        @(posedge clk); #1;
        check({tag, "_ready_pulse"}, 32'(cpu_ready), 32'd0);
        check({tag, "_stat_txn"},    32'(stat_txn_cnt), 32'(exp_txn));
        check({tag, "_stat_err"},    32'(stat_err_cnt), 32'(exp_err));
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        reset      = 1'b1;
        cpu_req    = 1'b0;
        cpu_addr   = 32'h0;
        cpu_wdata  = 32'h0;
        cpu_byteen = 4'b0000;
        s_ack      = 4'b0000;
        for (int i = 0; i < 4; i++) slave_data[i] = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",  32'(cpu_ready), 32'd0);
        check("rst_err",    32'(cpu_err),   32'd0);
        check("rst_rdata",  cpu_rdata,      32'h0);
        check("rst_sel",    32'(s_sel),     32'd0);
        check("rst_addr",   s_addr,         32'h0);
        check("rst_stat",   32'({stat_txn_cnt, stat_err_cnt}), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Directed scenarios and map boundaries.
        begin
            run_txn("dm_read", 32'h0000_0010, 32'h0, 4'b0000, 0, 1'b0);
        end
        slave_data[0] = 32'hDEADBEEF;
        run_txn("tc1_write", 32'h0000_7F14, 32'h1234_5678, 4'b1111, 2, 1'b0);
        run_txn("hole_7f0c", 32'h0000_7F0C, 32'h0, 4'b0000, 0, 1'b0);
        run_txn("ig_timeout", 32'h0000_7F20, 32'h0, 4'b0000, 99, 1'b0);
        run_txn("dm_wrong_ack", 32'h0000_0100, 32'h0, 4'b0000, 1, 1'b0);
        run_txn("ack_at_timeout", 32'h0000_7F00, 32'h0, 4'b0000, TO - 1, 1'b0);
        run_txn("dm_top", 32'h0000_2FFF, 32'h0, 4'b0000, 0, 1'b1);
        run_txn("hole_3000", 32'h0000_3000, 32'h0, 4'b0000, 0, 1'b0);
        run_txn("tc0_top", 32'h0000_7F0B, 32'hA5A5_0000, 4'b0011, 4, 1'b1);
        run_txn("hole_7f1c", 32'h0000_7F1C, 32'h0, 4'b0000, 0, 1'b0);
        run_txn("ig_top", 32'h0000_7F23, 32'h0, 4'b0000, 0, 1'b0);
        run_txn("hole_7f24", 32'h0000_7F24, 32'h0, 4'b0000, 0, 1'b0);
        run_txn("hole_high", 32'h0001_0010, 32'h0, 4'b0000, 0, 1'b0);

        // Reset while WAITing: select drops at once and no ready appears.
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_0200;
        s_ack    = 4'b0000;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_pre_sel", 32'(s_sel), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_sel",   32'(s_sel),     32'd0);
        check("mid_rst_ready", 32'(cpu_ready), 32'd0);
        check("mid_rst_addr",  s_addr,         32'h0);
        s_ack = 4'b0001;
        repeat (2) begin
            @(posedge clk); #1;
            check("mid_rst_no_ready", 32'(cpu_ready), 32'd0);
        end
        check("mid_rst_stat", 32'({stat_txn_cnt, stat_err_cnt}), 32'h0);
        exp_txn = 0;
        exp_err = 0;
        @(negedge clk);
        reset = 1'b0;
        s_ack = 4'b0000;
        run_txn("post_rst", 32'h0000_0040, 32'h0, 4'b0000, 1, 1'b0);

        // Random accesses across every window and the holes.
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 5);
            case (r)
                0:       a = 32'($urandom_range(0, 32'h2FFF));
                1:       a = 32'h7F00 + 32'($urandom_range(0, 11));
                2:       a = 32'h7F10 + 32'($urandom_range(0, 11));
                3:       a = 32'h7F20 + 32'($urandom_range(0, 3));
                4:       a = 32'h3000 + 32'($urandom_range(0, 32'h4F40));
                default: a = $urandom;
            endcase
            run_txn($sformatf("rnd%0d", i), a, $urandom,
                    ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15)),
                    $urandom_range(0, 18), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
